// File: rtl/vc_trace_rr_arbiter.sv
// Round-robin trace arbiter: tags accepted records with {stamp, id} into a 2-entry output queue.
// Optional stall counter port enabled by defining VC_TRACE_ARB_STALL_CNT_EN.
module vc_trace_rr_arbiter #(
    parameter int NREQS      = 4,
    parameter int NUMBITS    = 32,
    parameter int ID_BITS    = 3,
    parameter int STAMP_BITS = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NREQS-1:0]                      in_val,
    output logic [NREQS-1:0]                      in_rdy,
    input  logic [NREQS*NUMBITS-1:0]              in_bits,
    output logic                                  out_val,
    input  logic                                  out_rdy,
`ifdef VC_TRACE_ARB_STALL_CNT_EN
    output logic [STAMP_BITS+ID_BITS+NUMBITS-1:0] out_bits,
    output logic [15:0]                           stall_cnt
`else
    output logic [STAMP_BITS+ID_BITS+NUMBITS-1:0] out_bits
`endif
);

    localparam int unsigned NR  = NREQS;
    localparam int unsigned REC = STAMP_BITS + ID_BITS + NUMBITS;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t                  state;
    logic [REC-1:0]          head;
    logic [REC-1:0]          tail;
    logic [ID_BITS-1:0]      ptr;
    logic [STAMP_BITS-1:0]   stamp;

    logic [2*NREQS-1:0]      dbl;
    logic [NREQS-1:0]        rot;
    logic                    found;
    logic [ID_BITS-1:0]      gnt;
    int unsigned             sum;
    logic [NUMBITS-1:0]      pay;
    logic                    xfer;
    logic                    deq;
    logic [REC-1:0]          rec;

    // Rotate requests so bit 0 is the current priority holder; first set bit wins.
    assign dbl = {in_val, in_val} >> ptr;
    assign rot = dbl[NREQS-1:0];

    always_comb begin
        found = 1'b0;
        gnt   = '0;
        sum   = 0;
        for (int unsigned i = 0; i < NR; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                sum   = 32'(ptr) + i;
                if (sum >= NR) sum = sum - NR;
                gnt   = ID_BITS'(sum);
            end
        end
    end

    always_comb begin
        pay = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            if (gnt == ID_BITS'(i)) pay = in_bits[i*NUMBITS +: NUMBITS];
        end
    end

    // Grant depends only on queue state and in_val, never on out_rdy.
    assign in_rdy  = (found && state != FULL && !reset) ? (NREQS'(1) << gnt) : '0;
    assign xfer    = |(in_val & in_rdy);
    assign out_val = (state != EMPTY);
    assign deq     = out_val && out_rdy;
    assign out_bits = head;
    assign rec     = {stamp, gnt, pay};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
            head  <= '0;
            tail  <= '0;
            ptr   <= '0;
            stamp <= '0;
        end else begin
            stamp <= stamp + 1'b1;
            if (xfer) ptr <= (gnt == ID_BITS'(NREQS-1)) ? '0 : gnt + 1'b1;
            case (state)
                EMPTY: begin
                    if (xfer) begin
                        head  <= rec;
                        state <= ONE;
                    end
                end
                ONE: begin
                    if (xfer && deq) begin
                        head <= rec;
                    end else if (xfer) begin
                        tail  <= rec;
                        state <= FULL;
                    end else if (deq) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (deq) begin
                        head  <= tail;
                        state <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef VC_TRACE_ARB_STALL_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (|in_val && !xfer && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vc_trace_rr_arbiter.sv
// Directed bench for vc_trace_rr_arbiter: a default instance plus a 4-bit-stamp instance for wrap checks.
module tb_vc_trace_rr_arbiter;

    logic          clk;
    logic          reset;
    logic [3:0]    in_val;
    logic [127:0]  in_bits;
    logic          out_rdy;

    logic [3:0]    in_rdy;
    logic          out_val;
    logic [50:0]   out_bits;
    logic [3:0]    in_rdy4;
    logic          out_val4;
    logic [38:0]   out_bits4;
`ifdef VC_TRACE_ARB_STALL_CNT_EN
    logic [15:0]   stall_cnt;
    logic [15:0]   stall_cnt4;
`endif

    int total = 0;
    int bad   = 0;

    vc_trace_rr_arbiter #(.NREQS(4), .NUMBITS(32), .ID_BITS(3), .STAMP_BITS(16)) dut (
        .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy), .in_bits(in_bits),
        .out_val(out_val), .out_rdy(out_rdy),
`ifdef VC_TRACE_ARB_STALL_CNT_EN
        .out_bits(out_bits), .stall_cnt(stall_cnt)
`else
        .out_bits(out_bits)
`endif
    );

    vc_trace_rr_arbiter #(.NREQS(4), .NUMBITS(32), .ID_BITS(3), .STAMP_BITS(4)) dut4 (
        .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy4), .in_bits(in_bits),
        .out_val(out_val4), .out_rdy(out_rdy),
`ifdef VC_TRACE_ARB_STALL_CNT_EN
        .out_bits(out_bits4), .stall_cnt(stall_cnt4)
`else
        .out_bits(out_bits4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    function automatic logic [63:0] rec16(input int st, input int id, input logic [31:0] p);
        return {13'b0, 16'(st), 3'(id), p};
    endfunction

    function automatic logic [63:0] rec4(input int st, input int id, input logic [31:0] p);
        return {25'b0, 4'(st), 3'(id), p};
    endfunction

    function automatic logic [31:0] pl(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    task automatic set_all_bits();
        for (int i = 0; i < 4; i++) in_bits[i*32 +: 32] = pl(i);
    endtask

    initial begin
        reset   = 1'b1;
        in_val  = 4'hF;
        in_bits = '0;
        out_rdy = 1'b0;
        #1;
        chk("rst_out_val", 64'(out_val), 64'd0);
        chk("rst_out_bits", 64'(out_bits), 64'd0);
        chk("rst_in_rdy", 64'(in_rdy), 64'd0);

        // Single source at stamp 5
        in_val = 4'h0;
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        in_bits = '0;
        in_bits[2*32 +: 32] = 32'hA5;
        in_val  = 4'b0100;
        out_rdy = 1'b1;
        #1;
        chk("single_rdy", 64'(in_rdy), 64'b0100);
        tick();
        in_val = 4'h0;
        chk("single_val", 64'(out_val), 64'd1);
        chk("single_bits", 64'(out_bits), rec16(5, 2, 32'hA5));
        tick();
        chk("single_drained", 64'(out_val), 64'd0);

        // Round-robin fairness, one record per cycle
        do_reset();
        set_all_bits();
        in_val  = 4'hF;
        out_rdy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr_grant", 64'(in_rdy), 64'(4'b0001 << (k % 4)));
            tick();
            chk("rr_val", 64'(out_val), 64'd1);
            chk("rr_bits", 64'(out_bits), rec16(k, k % 4, pl(k % 4)));
        end

        // Backpressure: two accepted, then frozen
        do_reset();
        in_val  = 4'hF;
        out_rdy = 1'b0;
        #1;
        chk("bp_grant0", 64'(in_rdy), 64'b0001);
        tick();
        chk("bp_grant1", 64'(in_rdy), 64'b0010);
        chk("bp_head0", 64'(out_bits), rec16(0, 0, pl(0)));
        tick();
        chk("bp_full_rdy", 64'(in_rdy), 64'd0);
        chk("bp_full_head", 64'(out_bits), rec16(0, 0, pl(0)));
        tick();
        chk("bp_still_rdy", 64'(in_rdy), 64'd0);
        out_rdy = 1'b1;
        #1;
        chk("bp_no_outrdy_path", 64'(in_rdy), 64'd0);
        chk("bp_frozen", 64'(out_bits), rec16(0, 0, pl(0)));
        tick();
        chk("bp_after_drain_head", 64'(out_bits), rec16(1, 1, pl(1)));
        chk("bp_grant2", 64'(in_rdy), 64'b0100);
        tick();
        chk("bp_enq_deq_head", 64'(out_bits), rec16(4, 2, pl(2)));
        chk("bp_enq_deq_val", 64'(out_val), 64'd1);

        // Stamp wrap on the 4-bit instance
        do_reset();
        in_val  = 4'h0;
        out_rdy = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        in_val = 4'b0001;
        tick();
        chk("wrap_14", 64'(out_bits4), rec4(14, 0, pl(0)));
        tick();
        chk("wrap_15", 64'(out_bits4), rec4(15, 0, pl(0)));
        tick();
        chk("wrap_0", 64'(out_bits4), rec4(0, 0, pl(0)));
        chk("nowrap_16", 64'(out_bits), rec16(16, 0, pl(0)));

        // Async reset with queue full
        do_reset();
        in_val  = 4'hF;
        out_rdy = 1'b0;
        tick();
        tick();
        chk("ar_full_val", 64'(out_val), 64'd1);
        chk("ar_full_rdy", 64'(in_rdy), 64'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_val", 64'(out_val), 64'd0);
        chk("ar_rdy", 64'(in_rdy), 64'd0);
        chk("ar_bits", 64'(out_bits), 64'd0);
        #1;
        reset = 1'b0;
        #1;
        chk("ar_first_grant", 64'(in_rdy), 64'b0001);
        tick();
        chk("ar_first_rec", 64'(out_bits), rec16(0, 0, pl(0)));
        chk("ar_first_val", 64'(out_val), 64'd1);

`ifdef VC_TRACE_ARB_STALL_CNT_EN
        do_reset();
        in_val  = 4'b0010;
        out_rdy = 1'b0;
        #1;
        chk("stall_rst", 64'(stall_cnt), 64'd0);
        for (int i = 0; i < 10; i++) tick();
        chk("stall_cnt", 64'(stall_cnt), 64'd8);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vc_trace_rr_arbiter.md
# vc_trace_rr_arbiter

Round-robin arbiter that shares one trace-record output channel among NREQS val/rdy trace sources. Each accepted record is tagged with the source index and a free-running cycle stamp, then held in a 2-entry output queue. It sits between per-unit trace taps and the single trace sink/formatter, so several units can emit trace records through one channel without contention.

## Interface
- NREQS, 4: number of requesters; legal range 2..8.
- NUMBITS, 32: payload width per requester.
- ID_BITS, 3: source-index field width; must satisfy NREQS <= 2**ID_BITS.
- STAMP_BITS, 16: cycle-stamp width.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_val  input  NREQS  per-requester valid.
- in_rdy  output  NREQS  per-requester ready (grant); at most one bit high.
- in_bits  input  NREQS*NUMBITS  payloads; requester i occupies bits [i*NUMBITS +: NUMBITS].
- out_val  output  1  output record valid.
- out_rdy  input  1  sink ready.
- out_bits  output  STAMP_BITS+ID_BITS+NUMBITS  output record as {stamp, id, payload}.

## Operation
- Stamp counter:
  - Resets to 0.
  - Increments by 1 every cycle and wraps modulo 2**STAMP_BITS.
  - The stamp in a record is the counter value in the cycle of acceptance.
- Priority pointer `ptr`:
  - Resets to 0.
  - Grant goes to the first asserted in_val scanning ptr, ptr+1, …, wrapping at NREQS.
  - On a transfer from requester g, ptr becomes (g+1) mod NREQS.
  - With no transfer, ptr holds.
- Grant:
  - in_rdy[g] = 1 only for the selected requester, and only when the queue count < 2.
  - in_rdy never depends on out_rdy; there is no combinational path from out_rdy to in_rdy.
  - in_rdy does depend combinationally on in_val.
- Transfer (in_val[g] && in_rdy[g]) enqueues {stamp, g, in_bits[g]}.
- Output queue is a 2-entry FIFO with states EMPTY, ONE, FULL:
  - EMPTY --enq--> ONE.
  - ONE --enq & !deq--> FULL.
  - ONE --deq & !enq--> EMPTY.
  - ONE --enq & deq--> ONE (head replaced by the new record).
  - FULL --deq--> ONE.
  - In FULL no enqueue is possible, since all in_rdy are 0.
- Dequeue occurs when out_val && out_rdy.
- out_val = (state != EMPTY). out_bits is the head entry and is held stable while out_val && !out_rdy.
- Requesters not granted see in_rdy = 0 and must hold their val/bits. The round-robin scheme guarantees a valid requester is granted within NREQS transfers.
- Reset outputs:
  - in_rdy = 0 (registered-state portion; queue EMPTY, ptr 0).
  - out_val = 0.
  - out_bits = 0.
- Reset mid-operation discards queued records immediately (asynchronously); the stamp and ptr return to 0.

## Timing
- Latency: a record accepted in cycle t is presented on out_val/out_bits in cycle t+1 at the earliest. There is no same-cycle bypass.
- Throughput: one record per cycle sustained while out_rdy = 1.
- With out_rdy = 0 the arbiter accepts exactly 2 records, then stalls all requesters.
- When FULL and out_rdy rises in cycle t: the dequeue happens at the end of t, and in_rdy can assert in t+1.
- Simultaneous enqueue and dequeue in ONE keeps one record in the queue; the newly accepted record becomes head in the next cycle.
- Stamp wrap: a record accepted when the counter is 2**STAMP_BITS-1 carries that value; the next cycle's stamp is 0.

## Configuration
- VC_TRACE_ARB_STALL_CNT_EN defined:
  - Adds output port stall_cnt [15:0].
  - Counts cycles in which any in_val is high but no transfer occurs.
  - Saturates at 16'hFFFF.
  - Resets to 0.
- Not defined: port and counter are absent; all other behaviour is identical.

## Test plan
- Single source: NREQS=4, only in_val[2]=1 with bits 0xA5, out_rdy=1, released at stamp 5 -> next cycle out_val=1, out_bits={16'd5, 3'd2, 32'hA5}, then out_val=0.
- Round-robin fairness: all four in_val held high, out_rdy=1 -> grants go to 0,1,2,3,0,1 in consecutive cycles, one record per cycle.
- Backpressure: all in_val high, out_rdy=0 -> exactly 2 records (ids 0,1) accepted, all in_rdy=0 thereafter, out_bits frozen at the id-0 record. Raising out_rdy drains id 0, then accepts id 2.
- Stamp wrap: STAMP_BITS=4, transfers in cycles 14,15,16 -> stamps 14,15,0.
- Async reset mid-flight: with queue FULL, pulse reset between clock edges -> out_val=0 and in_rdy=0 immediately. After release, the first grant goes to requester 0 with stamp reflecting cycles since reset.
- With VC_TRACE_ARB_STALL_CNT_EN: in_val[1]=1, out_rdy=0 for 10 cycles -> 2 transfers, then stall_cnt=8.
